// File: rtl/mul_ctrl.sv
// Multi-cycle sequencer for the external 32x32 multiplier; owns HI/LO and the pipeline stall.
// Optional MADD/MADDU accumulate path is built only when MUL_CTRL_ACC_EN is defined.
module mul_ctrl #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mult_res,
  input  logic [63:0] multu_res,
  input  logic        hilo_rd,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_sel_u;
  logic            w_accept;
  logic            w_wb;
  logic [2*DW-1:0] w_prod;
  logic [2*DW-1:0] w_hilo_nxt;

`ifdef MUL_CTRL_ACC_EN
  logic            r_acc;
`else
  logic            w_unused_op1;
  assign w_unused_op1 = op[1];
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-derived outputs and strobes; stall is purely combinational from busy
  always_comb begin
    ready    = 1'b0;
    busy     = 1'b0;
    case (r_state)
      S_IDLE:  ready = 1'b1;
      S_BUSY:  busy  = 1'b1;
      default: ready = 1'b0;
    endcase
    stall    = busy & (hilo_rd | mthi | mtlo | start);
    w_accept = ready & start;
    w_wb     = busy & (r_cnt == '0);
  end

  assign w_prod = r_sel_u ? multu_res : mult_res;

`ifdef MUL_CTRL_ACC_EN
  assign w_hilo_nxt = r_acc ? ({hi, lo} + w_prod) : w_prod;
`else
  assign w_hilo_nxt = w_prod;
`endif

  // Operand latch and latency counter; operands stay frozen for the whole BUSY window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      r_sel_u <= 1'b0;
`ifdef MUL_CTRL_ACC_EN
      r_acc   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_cnt   <= CW'(LATENCY - 1);
      mul_a   <= a;
      mul_b   <= b;
      r_sel_u <= op[0];
`ifdef MUL_CTRL_ACC_EN
      r_acc   <= op[1];
`endif
    end else if (busy && (r_cnt != '0)) begin
      r_cnt   <= r_cnt - CW'(1);
    end
  end

  // HI/LO: product writeback in BUSY, MTHI/MTLO only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= w_wb;
      if (w_wb) begin
        {hi, lo} <= w_hilo_nxt;
      end else if (ready) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: directed cases plus randomized ops against an arithmetic HI/LO model.
module tb_mul_ctrl;

  localparam int unsigned LAT = 4;
`ifdef MUL_CTRL_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start1;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        hilo_rd, mthi, mtlo;
  logic        ready, busy, stall, done;
  logic [31:0] mul_a, mul_b, hi, lo;
  logic [63:0] mult_res, multu_res;
  logic        ready1, busy1, stall1, done1;
  logic [31:0] mul_a1, mul_b1, hi1, lo1;
  logic [63:0] mult_res1, multu_res1;

  int checks = 0;
  int errors = 0;
  logic [63:0] m_hilo, m1_hilo;

  always #5 clk = ~clk;

  // Behavioural multiplier seen by each controller
  assign mult_res   = 64'($signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b}));
  assign multu_res  = {32'd0, mul_a} * {32'd0, mul_b};
  assign mult_res1  = 64'($signed({{32{mul_a1[31]}}, mul_a1}) * $signed({{32{mul_b1[31]}}, mul_b1}));
  assign multu_res1 = {32'd0, mul_a1} * {32'd0, mul_b1};

  mul_ctrl #(.LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .mul_a(mul_a), .mul_b(mul_b),
    .mult_res(mult_res), .multu_res(multu_res),
    .hilo_rd(hilo_rd), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  mul_ctrl #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op), .a(a), .b(b),
    .ready(ready1), .mul_a(mul_a1), .mul_b(mul_b1),
    .mult_res(mult_res1), .multu_res(multu_res1),
    .hilo_rd(1'b0), .mthi(1'b0), .mtlo(1'b0), .wdata(32'd0),
    .busy(busy1), .stall(stall1), .done(done1), .hi(hi1), .lo(lo1)
  );

  function automatic logic [63:0] ref_prod(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o[0]) return {32'd0, x} * {32'd0, y};
    return 64'(sx * sy);
  endfunction

  function automatic logic [63:0] ref_hilo(input logic [63:0] cur, input logic [1:0] o,
                                           input logic [31:0] x, input logic [31:0] y);
    if (ACC && o[1]) return cur + ref_prod(o, x, y);
    return ref_prod(o, x, y);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  // Issue one op at the current negedge and follow it through writeback
  task automatic do_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic whi, input logic wlo, input logic [31:0] wd);
    logic [63:0] exp;
    logic [3:0]  rq;
    check("ready_idle", 64'(ready), 64'd1);
    start = 1'b1; op = o; a = x; b = y;
    mthi = whi; mtlo = wlo; wdata = wd; hilo_rd = 1'b0;
    #1 check("stall_idle", 64'(stall), 64'd0);
    if (whi) m_hilo[63:32] = wd;
    if (wlo) m_hilo[31:0]  = wd;
    exp = ref_hilo(m_hilo, o, x, y);
    next();
    for (int k = 0; k < int'(LAT); k++) begin
      rq = 4'($urandom_range(0, 15));
      {start, hilo_rd, mthi, mtlo} = rq;
      wdata = $urandom; a = $urandom; b = $urandom;
      #1;
      check("busy", 64'(busy), 64'd1);
      check("ready_busy", 64'(ready), 64'd0);
      check("done_low", 64'(done), 64'd0);
      check("stall_busy", 64'(stall), 64'(rq != 4'd0));
      check("hilo_hold", {hi, lo}, m_hilo);
      check("operands_held", {mul_a, mul_b}, {x, y});
      next();
    end
    start = 1'b0; hilo_rd = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    #1;
    m_hilo = exp;
    check("busy_end", 64'(busy), 64'd0);
    check("done_pulse", 64'(done), 64'd1);
    check("hilo_wb", {hi, lo}, m_hilo);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; op = 2'b00; a = '0; b = '0;
    hilo_rd = 1'b1; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    m_hilo = '0; m1_hilo = '0;
    repeat (3) next();
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_operands", {mul_a, mul_b}, 64'd0);
    rst_n = 1'b1; hilo_rd = 1'b0;
    next();

    do_mul(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 32'd0);
    check("mult_neg2x3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_mul(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'd0);
    check("multu_ffx2", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    do_mul(2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'd0);
    check("mult_m1x2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

    next();
    check("done_one_cycle", 64'(done), 64'd0);
    mthi = 1'b1; wdata = 32'h1234_5678;
    next();
    mthi = 1'b0;
    m_hilo[63:32] = 32'h1234_5678;
    check("mthi_idle", 64'(hi), 64'h1234_5678);
    check("mthi_lo_kept", {hi, lo}, m_hilo);

`ifdef MUL_CTRL_ACC_EN
    mthi = 1'b1; wdata = 32'd0;
    next();
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'hFFFF_FFFF;
    next();
    mtlo = 1'b0;
    m_hilo = 64'h0000_0000_FFFF_FFFF;
    do_mul(2'b11, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0);
    check("maddu_carry", {hi, lo}, 64'h0000_0001_0000_0000);
`endif

    repeat (25) begin
      if ($urandom_range(0, 3) == 0) next();
      do_mul(2'($urandom_range(0, 3)), $urandom, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset in the middle of an operation abandons it
    next();
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
    next();
    start = 1'b0; hilo_rd = 1'b1;
    next();
    rst_n = 1'b0;
    #1;
    m_hilo = '0; m1_hilo = '0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_operands", {mul_a, mul_b}, 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    next();
    rst_n = 1'b1; hilo_rd = 1'b0;
    repeat (LAT + 1) begin
      next();
      check("no_done_after_rst", 64'(done), 64'd0);
    end
    do_mul(2'b00, 32'd7, 32'd9, 1'b0, 1'b0, 32'd0);
    check("mult_after_rst", {hi, lo}, 64'd63);

    // Single-cycle latency instance
    repeat (4) begin
      logic [63:0] exp1;
      next();
      op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom; start1 = 1'b1;
      exp1 = ref_hilo(m1_hilo, op, a, b);
      next();
      start1 = 1'b0;
      #1;
      check("l1_busy", 64'(busy1), 64'd1);
      check("l1_hold", {hi1, lo1}, m1_hilo);
      next();
      m1_hilo = exp1;
      check("l1_idle", 64'(busy1), 64'd0);
      check("l1_done", 64'(done1), 64'd1);
      check("l1_hilo", {hi1, lo1}, m1_hilo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
